// File: rtl/lc3b_types.sv
// Shared types for the LC-3b memory stage: state encoding and default-width word/mask types.
package lc3b_types;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned MASK_W = WORD_W / 8;

  typedef logic [WORD_W-1:0] lc3b_word;
  typedef logic [MASK_W-1:0] lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PTR  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } mem_state_e;

endpackage

// File: rtl/byte_lane_unit.sv
// Byte-lane helper: word-aligns the address, builds the byte enable,
// replicates store bytes across lanes and extracts/zero-extends load bytes.
module byte_lane_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               byte_op,
  input  logic [WIDTH-1:0]   addr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH-1:0]   rdata,
  output logic [WIDTH-1:0]   word_addr,
  output logic [WIDTH/8-1:0] byte_enable,
  output logic [WIDTH-1:0]   wdata_lane,
  output logic [WIDTH-1:0]   rdata_lane
);

  localparam int unsigned LANES = WIDTH / 8;
  localparam int unsigned LSEL  = $clog2(LANES);

  logic [LSEL-1:0] lane;
  logic [7:0]      sel_byte;

  assign lane = addr[LSEL-1:0];

  // Lane select, replicate and extract for the current effective address.
  always_comb begin
    word_addr            = addr;
    word_addr[LSEL-1:0]  = '0;
    sel_byte             = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (lane == LSEL'(i)) sel_byte = rdata[i*8 +: 8];
    end
    byte_enable = byte_op ? (LANES'(1) << lane) : '1;
    wdata_lane  = byte_op ? {LANES{wdata[7:0]}} : wdata;
    rdata_lane  = byte_op ? WIDTH'(sel_byte) : rdata;
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data memory controller: direct and indirect (pointer-first)
// loads/stores, word or byte sized, with registered memory strobes.
module mem_stage_ctrl
  import lc3b_types::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = WIDTH / 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic             req_read,
  input  logic             req_write,
  input  logic             req_indirect,
  input  logic             req_byte,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic             advance,
  input  logic             mem_resp,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [LANES-1:0] mem_byte_enable,
  output logic [WIDTH-1:0] rdata_out,
  output logic             done
);

  mem_state_e       state;
  logic             rst_seen;
  logic             cap_read;
  logic             cap_write;
  logic             cap_ind;
  logic             cap_byte;
  logic [WIDTH-1:0] cap_addr;
  logic [WIDTH-1:0] cap_wdata;
  logic [WIDTH-1:0] ptr;

  logic             req_present;
  logic             ln_byte;
  logic [WIDTH-1:0] ln_addr;
  logic [WIDTH-1:0] ln_wdata;
  logic [WIDTH-1:0] ln_word_addr;
  logic [LANES-1:0] ln_be;
  logic [WIDTH-1:0] ln_wdata_out;
  logic [WIDTH-1:0] ln_rdata_out;

  assign req_present = req_valid & (req_read | req_write);

  // Stage may advance when finished, or when idle with nothing to do.
  assign done = (state == DONE) | ((state == IDLE) & ~req_present);

  // Effective address feeding the lane unit: the incoming request while idle,
  // the freshly returned pointer while leaving PTR, otherwise the captured access.
  always_comb begin
    ln_byte  = cap_byte;
    ln_wdata = cap_wdata;
    ln_addr  = cap_ind ? ptr : cap_addr;
    case (state)
      IDLE: begin
        ln_byte  = req_byte;
        ln_wdata = req_wdata;
        ln_addr  = req_addr;
      end
      PTR:     ln_addr = mem_rdata;
      default: ;
    endcase
  end

  byte_lane_unit #(.WIDTH(WIDTH)) u_lanes (
    .byte_op     (ln_byte),
    .addr        (ln_addr),
    .wdata       (ln_wdata),
    .rdata       (mem_rdata),
    .word_addr   (ln_word_addr),
    .byte_enable (ln_be),
    .wdata_lane  (ln_wdata_out),
    .rdata_lane  (ln_rdata_out)
  );

  // Access sequencer with registered memory strobes and load result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      rst_seen        <= 1'b0;
      cap_read        <= 1'b0;
      cap_write       <= 1'b0;
      cap_ind         <= 1'b0;
      cap_byte        <= 1'b0;
      cap_addr        <= '0;
      cap_wdata       <= '0;
      ptr             <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
      rdata_out       <= '0;
    end else begin
      rst_seen <= 1'b1;
      case (state)
        IDLE: begin
          if (req_present && rst_seen) begin
            cap_read    <= req_read;
            cap_write   <= req_write;
            cap_ind     <= req_indirect;
            cap_byte    <= req_byte;
            cap_addr    <= req_addr;
            cap_wdata   <= req_wdata;
            mem_address <= ln_word_addr;
            if (req_indirect) begin
              // Pointer fetch is always a full-word read.
              state           <= PTR;
              mem_read        <= 1'b1;
              mem_write       <= 1'b0;
              mem_byte_enable <= '1;
              mem_wdata       <= '0;
            end else begin
              state           <= DATA;
              mem_read        <= req_read;
              mem_write       <= req_write;
              mem_byte_enable <= ln_be;
              mem_wdata       <= req_write ? ln_wdata_out : '0;
            end
          end
        end
        PTR: begin
          if (mem_resp) begin
            state           <= DATA;
            ptr             <= mem_rdata;
            mem_read        <= cap_read;
            mem_write       <= cap_write;
            mem_address     <= ln_word_addr;
            mem_byte_enable <= ln_be;
            mem_wdata       <= cap_write ? ln_wdata_out : '0;
          end
        end
        DATA: begin
          if (mem_resp) begin
            state           <= DONE;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
            if (cap_read) rdata_out <= ln_rdata_out;
          end
        end
        DONE: begin
          if (advance) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: expected memory accesses and
// completions are queued by the stimulus and checked by a negedge monitor.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_read = 1'b0, req_write = 1'b0;
  logic        req_indirect = 1'b0, req_byte = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        advance = 1'b0;
  logic        mon_resp = 1'b0, drv_resp = 1'b0;
  logic        mem_resp;
  logic [15:0] mem_rdata = '0;
  logic        mem_read, mem_write, done;
  logic [15:0] mem_address, mem_wdata, rdata_out;
  logic [1:0]  mem_byte_enable;

  assign mem_resp = mon_resp | drv_resp;

  // 32-bit instance for the wide-lane case
  logic        req_valid32 = 1'b0, req_write32 = 1'b0, req_byte32 = 1'b0;
  logic [31:0] req_addr32 = '0, req_wdata32 = '0;
  logic        mem_read32, mem_write32, done32, mem_resp32;
  logic [31:0] mem_address32, mem_wdata32, rdata_out32;
  logic [3:0]  mem_byte_enable32;
  logic        zero_bit = 1'b0, one_bit = 1'b1;
  logic [31:0] zero_word = '0;

  assign mem_resp32 = mem_read32 | mem_write32;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_read(req_read),
    .req_write(req_write), .req_indirect(req_indirect), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata), .advance(advance),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable), .rdata_out(rdata_out), .done(done)
  );

  mem_stage_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid32), .req_read(zero_bit),
    .req_write(req_write32), .req_indirect(zero_bit), .req_byte(req_byte32),
    .req_addr(req_addr32), .req_wdata(req_wdata32), .advance(one_bit),
    .mem_resp(mem_resp32), .mem_rdata(zero_word), .mem_read(mem_read32),
    .mem_write(mem_write32), .mem_address(mem_address32), .mem_wdata(mem_wdata32),
    .mem_byte_enable(mem_byte_enable32), .rdata_out(rdata_out32), .done(done32)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic        respond;
    logic [15:0] rdata;
  } acc_t;

  typedef struct {
    int          lat;
    logic [15:0] rdata;
  } cmp_t;

  acc_t acc_q[$];
  cmp_t cmp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   low_cnt = 0;
  logic prev_done = 1'b1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void exp_acc(input logic rd, input logic wr, input logic [15:0] addr,
                                  input logic [15:0] wd, input logic [1:0] be,
                                  input logic respond, input logic [15:0] rdata);
    acc_t e;
    e.rd = rd; e.wr = wr; e.addr = addr; e.wdata = wd; e.be = be;
    e.respond = respond; e.rdata = rdata;
    acc_q.push_back(e);
  endfunction

  function automatic void exp_cmp(input int lat, input logic [15:0] rdata);
    cmp_t c;
    c.lat = lat; c.rdata = rdata;
    cmp_q.push_back(c);
  endfunction

  // Monitor: each strobe cycle is one access (answered from the scoreboard);
  // each rising edge of done is one completion (latency and load result).
  always @(negedge clk) begin : monitor
    acc_t e;
    cmp_t c;
    if (mem_read || mem_write) begin
      if (acc_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL access_extra got r=%0b w=%0b addr=%h expected no access",
                 mem_read, mem_write, mem_address);
        mon_resp = 1'b0;
      end else begin
        e = acc_q.pop_front();
        check("access", {mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable},
              {e.rd, e.wr, e.addr, e.wdata, e.be});
        mon_resp  = e.respond;
        mem_rdata = e.rdata;
      end
    end else begin
      mon_resp  = 1'b0;
      mem_rdata = 16'hDEAD;
    end
    if (!done) begin
      low_cnt++;
    end else if (!prev_done) begin
      if (cmp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL completion_extra got lat=%0d rdata=%h expected none", low_cnt, rdata_out);
      end else begin
        c = cmp_q.pop_front();
        check("completion", {32'(low_cnt), rdata_out}, {32'(c.lat), c.rdata});
      end
      low_cnt = 0;
    end
    prev_done = done;
  end

  // Wait (bounded) for the DUT to show a strobe; returns with req unchanged.
  task automatic wait_strobe(output bit ok);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(mem_read || mem_write) && n < 20);
    ok = mem_read || mem_write;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL strobe_timeout got no strobe expected one within 20 cycles");
    end
  endtask

  // Issue one request, scramble req_* after acceptance, then advance out of DONE.
  task automatic do_op(input logic rd, input logic wr, input logic ind, input logic byt,
                       input logic [15:0] addr, input logic [15:0] wd);
    bit ok;
    int n = 0;
    req_valid = 1'b1; req_read = rd; req_write = wr;
    req_indirect = ind; req_byte = byt; req_addr = addr; req_wdata = wd;
    wait_strobe(ok);
    req_read = wr; req_write = rd; req_indirect = ~ind; req_byte = ~byt;
    req_addr = ~addr; req_wdata = ~wd;
    while (!done && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout got done=0 expected done=1 within 20 cycles");
    end
    req_valid = 1'b0;
    advance = 1'b1;
    @(posedge clk); #1;
    advance = 1'b0;
  endtask

  initial begin : stim
    bit ok;
    #12;
    check("reset_state", {mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, rdata_out, done},
          {1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 16'h0, 1'b1});
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // LDR direct word read
    exp_acc(1, 0, 16'h1004, 16'h0000, 2'b11, 1, 16'hBEEF);
    exp_cmp(2, 16'hBEEF);
    do_op(1, 0, 0, 0, 16'h1004, 16'h0000);

    // LDI: pointer fetch then data read
    exp_acc(1, 0, 16'h2000, 16'h0000, 2'b11, 1, 16'h3002);
    exp_acc(1, 0, 16'h3002, 16'h0000, 2'b11, 1, 16'h1234);
    exp_cmp(3, 16'h1234);
    do_op(1, 0, 1, 0, 16'h2000, 16'h0000);

    // STB upper lane: replicated data, rdata_out held
    exp_acc(0, 1, 16'h4000, 16'hABAB, 2'b10, 1, 16'h0000);
    exp_cmp(2, 16'h1234);
    do_op(0, 1, 0, 1, 16'h4001, 16'h00AB);

    // LDB upper lane
    exp_acc(1, 0, 16'h4000, 16'h0000, 2'b10, 1, 16'hCD12);
    exp_cmp(2, 16'h00CD);
    do_op(1, 0, 0, 1, 16'h4001, 16'h0000);

    // STW at odd address: word aligned, full enable
    exp_acc(0, 1, 16'h5002, 16'h1357, 2'b11, 1, 16'h0000);
    exp_cmp(2, 16'h00CD);
    do_op(0, 1, 0, 0, 16'h5003, 16'h1357);

    // LDB lower lane
    exp_acc(1, 0, 16'h6000, 16'h0000, 2'b01, 1, 16'hCD12);
    exp_cmp(2, 16'h0012);
    do_op(1, 0, 0, 1, 16'h6000, 16'h0000);

    // Indirect byte load: full-word pointer fetch, byte data read via pointer lane
    exp_acc(1, 0, 16'h7000, 16'h0000, 2'b11, 1, 16'h8003);
    exp_acc(1, 0, 16'h8002, 16'h0000, 2'b10, 1, 16'h5AA5);
    exp_cmp(3, 16'h005A);
    do_op(1, 0, 1, 1, 16'h7001, 16'h0000);

    // STI word: write through pointer
    exp_acc(1, 0, 16'h9000, 16'h0000, 2'b11, 1, 16'hA005);
    exp_acc(0, 1, 16'hA004, 16'hCAFE, 2'b11, 1, 16'h0000);
    exp_cmp(3, 16'h005A);
    do_op(0, 1, 1, 0, 16'h9000, 16'hCAFE);

    // Reset while in PTR, then a late response
    exp_acc(1, 0, 16'h2000, 16'h0000, 2'b11, 0, 16'h0000);
    exp_cmp(2, 16'h0000);
    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
    req_indirect = 1'b1; req_byte = 1'b0; req_addr = 16'h2000; req_wdata = 16'h0;
    wait_strobe(ok);
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("reset_strobes", {mem_read, mem_write, mem_address, mem_byte_enable},
          {1'b0, 1'b0, 16'h0, 2'b00});
    drv_resp = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("late_resp_ignored", {mem_read, mem_write, rdata_out, done},
          {1'b0, 1'b0, 16'h0, 1'b1});
    drv_resp = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;

    // Request present at reset release waits one extra edge
    reset_n = 1'b1;
    exp_acc(1, 0, 16'h0A0A, 16'h0000, 2'b11, 1, 16'h4242);
    exp_cmp(3, 16'h4242);
    do_op(1, 0, 0, 0, 16'h0A0A, 16'h0000);

    // 32-bit STB at lane 3
    req_valid32 = 1'b1; req_write32 = 1'b1; req_byte32 = 1'b1;
    req_addr32 = 32'h0000_0103; req_wdata32 = 32'h0000_00AB;
    begin
      int n = 0;
      do begin
        @(posedge clk); #1; n++;
      end while (!mem_write32 && n < 20);
    end
    check("stb32", {mem_write32, mem_address32, mem_byte_enable32, mem_wdata32},
          {1'b1, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB});
    req_valid32 = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    check("acc_queue_empty", 128'(acc_q.size()), 128'(0));
    check("cmp_queue_empty", 128'(cmp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
